scr1_accel_pix_window: RTL and testbench
========================================

// Module: scr1_accel_pix_window
// PURPOSE
//  Upstream feeder for the memory-mapped pixel accelerator.
//  - Takes a raster-order 8-bit pixel stream, one row of IMG_W pixels at a time.
//  - Holds the previous row in an internal line buffer.
//  - Emits every stride-1 2x2 neighbourhood as one packed 32-bit word, ready for the accelerator's 4-pixel weighting.
//  - Valid/ready handshakes on both sides; a frame is armed by a start pulse.
// PARAMETERS
//  IMG_W   32                 pixels per row (>=2)
//  IMG_H   32                 rows per frame (>=2)
//  CW      $clog2(IMG_W)      column counter width (derived, do not override)
//  RW      $clog2(IMG_H)      row counter width (derived, do not override)
// PORTS
//  clk         in   1    clock
//  rst_n       in   1    reset, asynchronous, active-low
//  start       in   1    1-cycle pulse: arm/restart frame capture
//  pix_valid   in   1    pixel present on pix_data
//  pix_data    in   8    pixel value
//  pix_ready   out  1    block accepts pixel this cycle
//  win_valid   out  1    window word present
//  win_data    out  32   [7:0]=top-left, [15:8]=top-right, [23:16]=bottom-left, [31:24]=bottom-right
//  win_last    out  1    qualifies win_data: final window of frame
//  win_ready   in   1    consumer takes window this cycle
//  busy        out  1    state != IDLE
//  frame_done  out  1    1-cycle pulse after final window handshake
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; col=0; row=0. Line buffer is not cleared.
//  States:
//   - IDLE -> RUN on start.
//   - RUN -> DRAIN on acceptance of pixel (row=IMG_H-1, col=IMG_W-1).
//   - DRAIN -> IDLE on win_valid&&win_ready; frame_done=1 in that transition's next cycle.
//  start in any state:
//   - col=0, row=0, win_valid=0, win_last=0, state=RUN.
//   - An in-flight window is discarded; no frame_done.
//  pix_ready = (state==RUN) && !start && (!win_valid || win_ready).
//  Pixel accept (acc = pix_valid && pix_ready) at position (row, col), all in one cycle:
//   - tl_q <= lb[col];  lb[col] <= pix_data;  left_q <= pix_data.
//   - col++ ; on col==IMG_W-1: col=0 and row++.
//  Window generation:
//   - A window is produced only when acc && row>=1 && col>=1.
//   - Next cycle: win_valid=1, win_data={pix_data, left_q, lb[col], tl_q}, all sampled before the updates above.
//   - win_last=1 iff (row, col) == (IMG_H-1, IMG_W-1).
//  Latency: accepted pixel -> window valid = 1 cycle.
//  Windows per frame: (IMG_W-1)*(IMG_H-1).
//  Row 0 and column 0 pixels only fill state; they produce no output.
//  Output register:
//   - Holds win_data/win_last stable while win_valid && !win_ready.
//   - Clears win_valid on handshake unless a new window loads in the same cycle; a new window loads seamlessly, giving 1 pixel/cycle throughput.
//  Boundary behaviour:
//   - Column wrap: left_q/tl_q from the previous row's end are never used, because the col>=1 gate masks them.
//   - Row counter does not wrap; DRAIN blocks further input.
//   - pix_valid in IDLE/DRAIN: ignored, pix_ready=0, no state change.
//   - Reset mid-frame: immediate return to reset values; window lost.
// TESTING
//  1. IMG_W=IMG_H=4, pixels 0..15 back-to-back, win_ready=1.
//     -> 9 windows; first 0x05040100; last 0x0F0E0B0A with win_last=1.
//     -> frame_done pulses 1 cycle later; busy falls.
//  2. Same frame, win_ready=0 for 5 cycles after first window.
//     -> win_data held at 0x05040100; pix_ready=0 while win_valid && !win_ready; no pixel or window lost.
//  3. pix_valid=1 with pix_data=0xAA while IDLE for 10 cycles, then start and frame.
//     -> no acceptance before start; windows identical to test 1.
//  4. start asserted after 7 pixels, then full frame 0..15.
//     -> output matches test 1 exactly; no frame_done for the aborted frame.
//  5. rst_n low for 1 cycle mid-frame.
//     -> all outputs 0, state IDLE; pix_ready=0 until start.
//  6. Random pix_valid/win_ready gaps, 32x32 random frame.
//     -> scoreboard 2x2 windows vs software model; count = 961.

Source files
------------

// File: rtl/scr1_accel_pix_window.sv
// 2x2 stride-1 window generator for the pixel accelerator.
// Keeps the previous row in a line buffer and emits packed neighbourhoods.
module scr1_accel_pix_window #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    localparam int CW = $clog2(IMG_W),
    localparam int RW = $clog2(IMG_H)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic        win_valid,
    output logic [31:0] win_data,
    output logic        win_last,
    input  logic        win_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    lb [IMG_W];
    logic [7:0]    tl_q;
    logic [7:0]    left_q;

    logic acc;
    logic gen;
    logic at_end;
    logic hs;

    assign pix_ready = (state == S_RUN) && !start
                     && (!win_valid || win_ready);
    assign acc    = pix_valid && pix_ready;
    assign at_end = (row == ROW_MAX) && (col == COL_MAX);
    // Row 0 and column 0 only prime the buffers.
    assign gen    = acc && (row != '0) && (col != '0);
    assign hs     = win_valid && win_ready;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                state <= S_RUN;
                col   <= '0;
                row   <= '0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (acc) begin
                            if (col == COL_MAX) begin
                                col <= '0;
                                if (at_end) state <= S_DRAIN;
                                else        row   <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (hs) begin
                            state      <= S_IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                    S_IDLE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Line buffer carries no reset; every entry is rewritten by row 0.
    always_ff @(posedge clk) begin
        if (acc) lb[col] <= pix_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tl_q      <= '0;
            left_q    <= '0;
            win_valid <= 1'b0;
            win_data  <= '0;
            win_last  <= 1'b0;
        end else begin
            if (acc) begin
                tl_q   <= lb[col];
                left_q <= pix_data;
            end
            if (start) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end else if (gen) begin
                win_valid <= 1'b1;
                win_data  <= {pix_data, left_q, lb[col], tl_q};
                win_last  <= at_end;
            end else if (hs) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scr1_accel_pix_window.sv
// Directed and random checks for scr1_accel_pix_window.
// A 4x4 instance covers directed cases; a 32x32 instance covers random gaps.
module tb_scr1_accel_pix_window;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_start, a_pv, a_pr, a_wv, a_wl, a_wr, a_busy, a_fd;
    logic [7:0]  a_pd;
    logic [31:0] a_wd;
    logic        b_start, b_pv, b_pr, b_wv, b_wl, b_wr, b_busy, b_fd;
    logic [7:0]  b_pd;
    logic [31:0] b_wd;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt;

    scr1_accel_pix_window #(.IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .pix_valid(a_pv), .pix_data(a_pd), .pix_ready(a_pr),
        .win_valid(a_wv), .win_data(a_wd), .win_last(a_wl),
        .win_ready(a_wr), .busy(a_busy), .frame_done(a_fd)
    );

    scr1_accel_pix_window #(.IMG_W(32), .IMG_H(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .pix_valid(b_pv), .pix_data(b_pd), .pix_ready(b_pr),
        .win_valid(b_wv), .win_data(b_wd), .win_last(b_wl),
        .win_ready(b_wr), .busy(b_busy), .frame_done(b_fd)
    );

    // Pixel value at (r,c) in the 4x4 test frame is r*4+c.
    function automatic logic [31:0] exp4(input int k);
        int r;
        int c;
        r = k / 3 + 1;
        c = k % 3 + 1;
        return {8'(r*4 + c), 8'(r*4 + c - 1),
                8'((r-1)*4 + c), 8'((r-1)*4 + c - 1)};
    endfunction

    task automatic pulse_start4();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    // Streams pixels 0..15 and scoreboards every window handshake.
    task automatic run4(input string tag, input int stall_len);
        int idx;
        int cyc;
        int k;
        int stall;
        bit done;
        idx = 0; cyc = 0; k = 0; stall = stall_len; done = 0;
        fd_cnt = 0;
        while (!done && cyc < 300) begin
            a_pv = (idx < 16);
            a_pd = 8'(idx);
            a_wr = 1'b1;
            if (a_wv && stall > 0) begin
                a_wr = 1'b0;
                stall--;
            end
            @(negedge clk);
            if (!a_wr) begin
                n_cmp++;
                if (a_wd !== 32'h05040100) begin
                    n_bad++;
                    $display("FAIL %s held: got %h want 05040100", tag, a_wd);
                end
                n_cmp++;
                if (a_pr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s stall_ready: got %b want 0", tag, a_pr);
                end
            end
            if (a_pv && a_pr) idx++;
            if (a_wv && a_wr) begin
                n_cmp++;
                if (k >= 9 || a_wd !== exp4(k) || a_wl !== (k == 8)) begin
                    n_bad++;
                    $display("FAIL %s win%0d: got %h/%b want %h/%b",
                             tag, k, a_wd, a_wl, exp4(k), k == 8);
                end
                k++;
            end
            if (a_fd) begin
                fd_cnt++;
                done = 1;
                n_cmp++;
                if (a_busy !== 1'b0 || k != 9) begin
                    n_bad++;
                    $display("FAIL %s done: busy %b wins %0d want 0/9",
                             tag, a_busy, k);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        a_pv = 1'b0;
        a_wr = 1'b1;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s timeout: got %0d windows want 9", tag, k);
        end
        @(negedge clk);
        n_cmp++;
        if (a_fd !== 1'b0) begin
            n_bad++;
            $display("FAIL %s fd_pulse: got %b want 0", tag, a_fd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_pr, a_wv, a_wd, a_wl, a_busy, a_fd} !== '0) begin
            n_bad++;
            $display("FAIL reset4: got %b/%b/%h/%b/%b/%b want all 0",
                     a_pr, a_wv, a_wd, a_wl, a_busy, a_fd);
        end
        n_cmp++;
        if ({b_pr, b_wv, b_wd, b_wl, b_busy, b_fd} !== '0) begin
            n_bad++;
            $display("FAIL reset32: got %b/%b/%h/%b/%b/%b want all 0",
                     b_pr, b_wv, b_wd, b_wl, b_busy, b_fd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        pulse_start4();
        run4("basic", 0);
    endtask

    task automatic test_backpressure();
        pulse_start4();
        run4("bp", 5);
    endtask

    task automatic test_idle_ignore();
        int acc_cnt;
        acc_cnt = 0;
        a_pv = 1'b1;
        a_pd = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_pr || a_wv) acc_cnt++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (acc_cnt != 0) begin
            n_bad++;
            $display("FAIL idle_accept: got %0d want 0", acc_cnt);
        end
        pulse_start4();
        run4("idle", 0);
    endtask

    task automatic test_restart();
        int idx;
        int cyc;
        int fd_seen;
        idx = 0; cyc = 0; fd_seen = 0;
        pulse_start4();
        a_wr = 1'b1;
        while (idx < 7 && cyc < 50) begin
            a_pv = 1'b1;
            a_pd = 8'(idx);
            @(negedge clk);
            if (a_pr) idx++;
            if (a_fd) fd_seen++;
            @(posedge clk); #1;
            cyc++;
        end
        a_pv = 1'b0;
        n_cmp++;
        if (idx != 7) begin
            n_bad++;
            $display("FAIL restart_fill: got %0d want 7", idx);
        end
        pulse_start4();
        @(negedge clk);
        if (a_fd) fd_seen++;
        n_cmp++;
        if (a_wv !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_flush: got %b want 0", a_wv);
        end
        @(posedge clk); #1;
        run4("restart", 0);
        n_cmp++;
        if (fd_seen != 0 || fd_cnt != 1) begin
            n_bad++;
            $display("FAIL restart_fd: got %0d/%0d want 0/1", fd_seen, fd_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        int cyc;
        idx = 0; cyc = 0;
        pulse_start4();
        a_wr = 1'b0;
        while (idx < 6 && cyc < 50) begin
            a_pv = 1'b1;
            a_pd = 8'(idx);
            @(negedge clk);
            if (a_pv && a_pr) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (a_wv !== 1'b1 || a_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre: got %b/%b want 1/1", a_wv, a_busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_pr, a_wv, a_wd, a_wl, a_busy, a_fd} !== '0) begin
            n_bad++;
            $display("FAIL midrst: got %b/%b/%h/%b/%b/%b want all 0",
                     a_pr, a_wv, a_wd, a_wl, a_busy, a_fd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (a_pr !== 1'b0 || a_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_idle: got %b/%b want 0/0", a_pr, a_busy);
            end
            @(posedge clk); #1;
        end
        a_pv = 1'b0;
        pulse_start4();
        run4("midrst", 0);
    endtask

    task automatic test_random();
        logic [7:0]  img [1024];
        logic [31:0] exp_w [961];
        int idx;
        int k;
        int cyc;
        int bad_before;
        bit done;
        for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
        for (int r = 1; r < 32; r++)
            for (int c = 1; c < 32; c++)
                exp_w[(r-1)*31 + (c-1)] = {img[r*32+c], img[r*32+c-1],
                                           img[(r-1)*32+c], img[(r-1)*32+c-1]};
        idx = 0; k = 0; cyc = 0; done = 0;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        bad_before = n_bad;
        while (!done && cyc < 20000) begin
            b_pv = (idx < 1024) && ($urandom_range(0, 3) != 0);
            b_pd = (idx < 1024) ? img[idx] : 8'h00;
            b_wr = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (b_pv && b_pr) idx++;
            if (b_wv && b_wr) begin
                n_cmp++;
                if (k >= 961) begin
                    n_bad++;
                    $display("FAIL rand_extra: window %0d got %h", k, b_wd);
                end else if (b_wd !== exp_w[k] || b_wl !== (k == 960)) begin
                    n_bad++;
                    if (n_bad - bad_before < 10)
                        $display("FAIL rand_win%0d: got %h/%b want %h/%b",
                                 k, b_wd, b_wl, exp_w[k], k == 960);
                end
                k++;
            end
            if (b_fd) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        b_pv = 1'b0;
        b_wr = 1'b0;
        n_cmp++;
        if (!done || k != 961) begin
            n_bad++;
            $display("FAIL rand_count: got %0d done %b want 961 done 1", k, done);
        end
    endtask

    initial begin
        a_start = 1'b0; a_pv = 1'b0; a_pd = '0; a_wr = 1'b1;
        b_start = 1'b0; b_pv = 1'b0; b_pd = '0; b_wr = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_idle_ignore();
        test_restart();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
